// File: rtl/pio_isr_push_ctrl.sv
// Per-state-machine ISR/RX FIFO push sequencer: decodes IN/PUSH strobes into
// ISR shift/clear and FIFO push commands, generates stall, keeps debug stats.
module pio_isr_push_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   penable,
  input  logic                   exec_in,
  input  logic                   exec_push,
  input  logic                   push_block,
  input  logic                   push_iffull,
  input  logic [4:0]             in_shift,
  input  logic                   autopush,
  input  logic [4:0]             push_thresh,
  input  logic [5:0]             isr_count,
  input  logic [5:0]             isr_count_next,
  input  logic                   rx_full,
  input  logic                   clear_stats,
  output logic                   isr_shift,
  output logic                   isr_clear,
  output logic                   push_sel,
  output logic                   fifo_push,
  output logic                   stall,
  output logic                   rx_stall_flag,
  output logic                   rx_drop_flag,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [5:0]             thr_s;
  logic                   shift_s;
  logic                   clear_s;
  logic                   sel_s;
  logic                   push_s;
  logic                   stall_s;
  logic                   stall_set_s;
  logic                   drop_set_s;
  logic                   unused_s;
  logic [0:0]             state_r;
  logic                   rx_stall_flag_r;
  logic                   rx_drop_flag_r;
  logic [STALL_CNT_W-1:0] stall_cycles_r;

  // The ISR applies in_shift itself; isr_count_next already reflects it.
  assign unused_s = ^in_shift;

  assign thr_s = (push_thresh == 5'd0) ? 6'd32 : {1'b0, push_thresh};

  // Command decode; exec_push has priority over exec_in.
  always_comb begin
    shift_s     = 1'b0;
    clear_s     = 1'b0;
    sel_s       = 1'b0;
    push_s      = 1'b0;
    stall_s     = 1'b0;
    stall_set_s = 1'b0;
    drop_set_s  = 1'b0;
    if (reset || !penable) begin
      stall_s = 1'b0;
    end else if (exec_push) begin
      if (push_iffull && (isr_count < thr_s)) begin
        stall_s = 1'b0;
      end else if (!rx_full) begin
        push_s  = 1'b1;
        clear_s = 1'b1;
      end else if (push_block) begin
        stall_s     = 1'b1;
        stall_set_s = 1'b1;
      end else begin
        clear_s    = 1'b1;
        drop_set_s = 1'b1;
      end
    end else if (exec_in) begin
      if (!autopush || (isr_count_next < thr_s)) begin
        shift_s = 1'b1;
      end else if (!rx_full) begin
        // Push the post-shift word and clear in the same cycle.
        shift_s = 1'b1;
        push_s  = 1'b1;
        sel_s   = 1'b1;
        clear_s = 1'b1;
      end else begin
        stall_s = 1'b1;
      end
    end else begin
      stall_s = 1'b0;
    end
  end

  assign isr_shift = shift_s;
  assign isr_clear = clear_s;
  assign push_sel  = sel_s;
  assign fifo_push = push_s;
  assign stall     = stall_s;

  // Stall-history FSM, sticky flags and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      rx_stall_flag_r <= 1'b0;
      rx_drop_flag_r  <= 1'b0;
      stall_cycles_r  <= '0;
    end else if (penable) begin
      case (state_r)
        ST_IDLE: state_r <= stall_s ? ST_WAIT : ST_IDLE;
        ST_WAIT: state_r <= stall_s ? ST_WAIT : ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase

      if (stall_set_s) begin
        rx_stall_flag_r <= 1'b1;
      end else if (clear_stats) begin
        rx_stall_flag_r <= 1'b0;
      end

      if (drop_set_s) begin
        rx_drop_flag_r <= 1'b1;
      end else if (clear_stats) begin
        rx_drop_flag_r <= 1'b0;
      end

      // A stall cycle coincident with clear_stats restarts the count at one.
      if (stall_s) begin
        if (clear_stats) begin
          stall_cycles_r <= CNT_ONE;
        end else if (stall_cycles_r != CNT_MAX) begin
          stall_cycles_r <= stall_cycles_r + CNT_ONE;
        end
      end else if (clear_stats) begin
        stall_cycles_r <= '0;
      end
    end
  end

  assign rx_stall_flag = rx_stall_flag_r;
  assign rx_drop_flag  = rx_drop_flag_r;
  assign stall_cycles  = stall_cycles_r;

endmodule

// File: tb/tb_pio_isr_push_ctrl.sv
// Scoreboard bench for pio_isr_push_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares them.
module tb_pio_isr_push_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        penable;
  logic        exec_in;
  logic        exec_push;
  logic        push_block;
  logic        push_iffull;
  logic [4:0]  in_shift;
  logic        autopush;
  logic [4:0]  push_thresh;
  logic [5:0]  isr_count;
  logic [5:0]  isr_count_next;
  logic        rx_full;
  logic        clear_stats;
  logic        isr_shift;
  logic        isr_clear;
  logic        push_sel;
  logic        fifo_push;
  logic        stall;
  logic        rx_stall_flag;
  logic        rx_drop_flag;
  logic [15:0] stall_cycles;

  typedef struct packed {
    logic [4:0]  cmd;   // {isr_shift, isr_clear, push_sel, fifo_push, stall}
    logic        sf;
    logic        df;
    logic [15:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  pio_isr_push_ctrl #(.STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .penable(penable), .exec_in(exec_in),
    .exec_push(exec_push), .push_block(push_block), .push_iffull(push_iffull),
    .in_shift(in_shift), .autopush(autopush), .push_thresh(push_thresh),
    .isr_count(isr_count), .isr_count_next(isr_count_next), .rx_full(rx_full),
    .clear_stats(clear_stats), .isr_shift(isr_shift), .isr_clear(isr_clear),
    .push_sel(push_sel), .fifo_push(fifo_push), .stall(stall),
    .rx_stall_flag(rx_stall_flag), .rx_drop_flag(rx_drop_flag),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Monitor: compares the oldest expectation against the settled outputs.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string n;
      logic [4:0] cmd;
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      cmd = {isr_shift, isr_clear, push_sel, fifo_push, stall};
      checks++;
      if (cmd !== e.cmd) begin
        errors++;
        $display("FAIL %s cmd: got %b expected %b", n, cmd, e.cmd);
      end
      checks++;
      if ({rx_stall_flag, rx_drop_flag, stall_cycles} !== {e.sf, e.df, e.cnt}) begin
        errors++;
        $display("FAIL %s stats: got sf=%b df=%b cnt=%0d expected sf=%b df=%b cnt=%0d",
                 n, rx_stall_flag, rx_drop_flag, stall_cycles, e.sf, e.df, e.cnt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [4:0] cmd, input logic sf,
                     input logic df, input logic [15:0] cnt);
    exp_t e;
    e.cmd = cmd;
    e.sf  = sf;
    e.df  = df;
    e.cnt = cnt;
    exp_q.push_back(e);
    name_q.push_back(n);
    tick();
  endtask

  initial begin
    reset = 1'b1; penable = 1'b0; exec_in = 1'b0; exec_push = 1'b0;
    push_block = 1'b0; push_iffull = 1'b0; in_shift = 5'd0; autopush = 1'b0;
    push_thresh = 5'd0; isr_count = 6'd0; isr_count_next = 6'd0;
    rx_full = 1'b0; clear_stats = 1'b0;
    tick(); tick();
    chk("reset", 5'b00000, 1'b0, 1'b0, 16'd0);
    reset = 1'b0;

    // Autopush at threshold 8
    penable = 1'b1; autopush = 1'b1; push_thresh = 5'd8; in_shift = 5'd4;
    isr_count = 6'd4; isr_count_next = 6'd8; exec_in = 1'b1;
    chk("ap_hit", 5'b11110, 1'b0, 1'b0, 16'd0);
    rx_full = 1'b1;
    chk("ap_stall0", 5'b00001, 1'b0, 1'b0, 16'd0);
    chk("ap_stall1", 5'b00001, 1'b0, 1'b0, 16'd1);
    chk("ap_stall2", 5'b00001, 1'b0, 1'b0, 16'd2);
    rx_full = 1'b0;
    chk("ap_release", 5'b11110, 1'b0, 1'b0, 16'd3);
    isr_count = 6'd2; isr_count_next = 6'd6;
    chk("ap_below", 5'b10000, 1'b0, 1'b0, 16'd3);
    autopush = 1'b0; isr_count = 6'd8; isr_count_next = 6'd12; rx_full = 1'b1;
    chk("no_autopush", 5'b10000, 1'b0, 1'b0, 16'd3);
    autopush = 1'b1; push_thresh = 5'd0; in_shift = 5'd0;
    isr_count = 6'd0; isr_count_next = 6'd32; rx_full = 1'b0;
    chk("thr32_hit", 5'b11110, 1'b0, 1'b0, 16'd3);
    isr_count_next = 6'd31;
    chk("thr32_below", 5'b10000, 1'b0, 1'b0, 16'd3);

    // PUSH block / noblock on full FIFO
    exec_in = 1'b0; exec_push = 1'b1; push_block = 1'b1; rx_full = 1'b1;
    chk("push_block", 5'b00001, 1'b0, 1'b0, 16'd3);
    push_block = 1'b0;
    chk("push_noblock", 5'b01000, 1'b1, 1'b0, 16'd4);
    exec_push = 1'b0; rx_full = 1'b0;
    chk("idle_flags", 5'b00000, 1'b1, 1'b1, 16'd4);
    exec_in = 1'b1; exec_push = 1'b1;
    chk("push_wins", 5'b01010, 1'b1, 1'b1, 16'd4);

    // IfFull against threshold 32
    exec_in = 1'b0; push_iffull = 1'b1; isr_count = 6'd31;
    chk("iffull_low", 5'b00000, 1'b1, 1'b1, 16'd4);
    isr_count = 6'd32;
    chk("iffull_hit", 5'b01010, 1'b1, 1'b1, 16'd4);
    isr_count = 6'd31; rx_full = 1'b1; push_block = 1'b1;
    chk("iffull_low_full", 5'b00000, 1'b1, 1'b1, 16'd4);

    // penable toggling during a blocking stall
    push_iffull = 1'b0;
    chk("pen_on0", 5'b00001, 1'b1, 1'b1, 16'd4);
    penable = 1'b0;
    chk("pen_off0", 5'b00000, 1'b1, 1'b1, 16'd5);
    penable = 1'b1;
    chk("pen_on1", 5'b00001, 1'b1, 1'b1, 16'd5);
    penable = 1'b0;
    chk("pen_off1", 5'b00000, 1'b1, 1'b1, 16'd6);

    // Reset mid-stall
    penable = 1'b1; reset = 1'b1;
    chk("reset_stall", 5'b00000, 1'b1, 1'b1, 16'd6);
    reset = 1'b0; penable = 1'b0;
    chk("after_reset", 5'b00000, 1'b0, 1'b0, 16'd0);

    // Saturation, then clear_stats coincident with a stall cycle
    penable = 1'b1; push_block = 1'b0;
    chk("drop", 5'b01000, 1'b0, 1'b0, 16'd0);
    push_block = 1'b1;
    chk("sat_first", 5'b00001, 1'b0, 1'b1, 16'd0);
    repeat (65540) tick();
    chk("sat", 5'b00001, 1'b1, 1'b1, 16'hFFFF);
    clear_stats = 1'b1;
    chk("clear_with_stall", 5'b00001, 1'b1, 1'b1, 16'hFFFF);
    clear_stats = 1'b0; exec_push = 1'b0; rx_full = 1'b0;
    chk("after_clear", 5'b00000, 1'b1, 1'b0, 16'd1);

    tick();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
